// File: rtl/bird_pkg.sv
// ============================================================================
//  Module      : bird_pkg
//  Description : Shared types and constants for the Flappy Bird controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

package bird_pkg;

    localparam int         COL_H     = 16;
    localparam logic [7:0] SCORE_MAX = 8'd255;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PLAY = 2'd1,
        DEAD = 2'd2
    } game_state_t;

endpackage

`default_nettype wire

// File: rtl/edge_detect.sv
// ============================================================================
//  Module      : edge_detect
//  Description : Rising-edge detector for a synchronized button level.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module edge_detect (
    input  logic Clock,
    input  logic RST,
    input  logic in,
    output logic rise
);

    logic in_q;

    always_ff @(posedge Clock) begin
        if (!RST) begin
            in_q <= 1'b0;
        end else begin
            in_q <= in;
        end
    end

    assign rise = in & ~in_q;

endmodule

`default_nettype wire

// File: rtl/bird_controller.sv
// ============================================================================
//  Module      : bird_controller
//  Description : Flap/gravity move sequencing, collision, score and game FSM.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module bird_controller #(
    parameter int GRAV_PERIOD = 4,
    parameter int FLAP_STEPS  = 2,
    parameter int COL_H       = bird_pkg::COL_H
) (
    input  logic             Clock,
    input  logic             RST,
    input  logic             tick,
    input  logic             flap,
    input  logic [COL_H-1:0] bird_pos,
    input  logic [COL_H-1:0] pipe_mask,
    input  logic             pipe_pass,
    output logic             move_up,
    output logic             move_down,
    output logic             col_clear,
    output logic             playing,
    output logic             game_over,
    output logic [7:0]       score
);

    import bird_pkg::*;

    localparam int CW = $clog2(FLAP_STEPS + 1);
    localparam int GW = (GRAV_PERIOD > 1) ? $clog2(GRAV_PERIOD) : 1;

    localparam logic [CW-1:0] CLIMB_INIT = CW'(FLAP_STEPS);
    localparam logic [GW-1:0] GRAV_LAST  = GW'(GRAV_PERIOD - 1);

    game_state_t   state, state_n;
    logic [CW-1:0] climb, climb_n;
    logic [GW-1:0] grav_cnt, grav_cnt_n;
    logic [7:0]    score_n;
    logic          move_up_n, move_down_n, col_clear_n;
    logic          flap_edge;
    logic          collision;

    edge_detect u_flap_edge (
        .Clock (Clock),
        .RST   (RST),
        .in    (flap),
        .rise  (flap_edge)
    );

    // An empty column means the bird has fallen off the bottom.
    assign collision = (|(bird_pos & pipe_mask)) || (bird_pos == '0);

    always_ff @(posedge Clock) begin
        if (!RST) begin
            state     <= IDLE;
            climb     <= '0;
            grav_cnt  <= '0;
            score     <= '0;
            move_up   <= 1'b0;
            move_down <= 1'b0;
            col_clear <= 1'b0;
        end else begin
            state     <= state_n;
            climb     <= climb_n;
            grav_cnt  <= grav_cnt_n;
            score     <= score_n;
            move_up   <= move_up_n;
            move_down <= move_down_n;
            col_clear <= col_clear_n;
        end
    end

    always_comb begin
        state_n     = state;
        climb_n     = climb;
        grav_cnt_n  = grav_cnt;
        score_n     = score;
        move_up_n   = 1'b0;
        move_down_n = 1'b0;
        col_clear_n = 1'b0;

        case (state)
            IDLE: begin
                if (flap_edge) begin
                    state_n    = PLAY;
                    climb_n    = CLIMB_INIT;
                    grav_cnt_n = '0;
                end
            end

            PLAY: begin
                if (collision) begin
                    state_n = DEAD;
                end else if (flap_edge) begin
                    // A tick arriving with the flap is swallowed by design.
                    climb_n    = CLIMB_INIT;
                    grav_cnt_n = '0;
                end else if (tick) begin
                    if (climb != '0) begin
                        if (bird_pos[COL_H-1]) begin
                            climb_n = '0;
                        end else begin
                            move_up_n  = 1'b1;
                            climb_n    = climb - 1'b1;
                            grav_cnt_n = '0;
                        end
                    end else if (grav_cnt < GRAV_LAST) begin
                        grav_cnt_n = grav_cnt + 1'b1;
                    end else if (bird_pos[0]) begin
                        state_n = DEAD;
                    end else begin
                        move_down_n = 1'b1;
                        grav_cnt_n  = '0;
                    end
                end

                if (pipe_pass && (score != SCORE_MAX)) begin
                    score_n = score + 8'd1;
                end
            end

            DEAD: begin
                if (flap_edge) begin
                    state_n     = IDLE;
                    col_clear_n = 1'b1;
                    score_n     = '0;
                    climb_n     = '0;
                    grav_cnt_n  = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase
    end

    always_comb begin
        playing   = (state == PLAY);
        game_over = (state == DEAD);
    end

endmodule

`default_nettype wire

// File: tb/tb_bird_controller.sv
// ============================================================================
//  Module      : tb_bird_controller
//  Description : Directed self-checking bench for bird_controller.
//  Revision    : 1.0
// ============================================================================
`default_nettype none

module tb_bird_controller;

    logic        Clock = 1'b0;
    logic        RST = 1'b0;
    logic        tick = 1'b0;
    logic        flap = 1'b0;
    logic [15:0] bird_pos = 16'h0100;
    logic [15:0] pipe_mask = 16'h0000;
    logic        pipe_pass = 1'b0;
    logic        move_up, move_down, col_clear, playing, game_over;
    logic [7:0]  score;

    int n_checks = 0;
    int n_fail   = 0;

    bird_controller #(
        .GRAV_PERIOD (4),
        .FLAP_STEPS  (2),
        .COL_H       (16)
    ) dut (
        .Clock     (Clock),
        .RST       (RST),
        .tick      (tick),
        .flap      (flap),
        .bird_pos  (bird_pos),
        .pipe_mask (pipe_mask),
        .pipe_pass (pipe_pass),
        .move_up   (move_up),
        .move_down (move_down),
        .col_clear (col_clear),
        .playing   (playing),
        .game_over (game_over),
        .score     (score)
    );

    always #5 Clock = ~Clock;

    // One clock with the given inputs; returns 1ns after the edge so the
    // registered outputs caused by these inputs are visible.
    task automatic cyc(input logic t, input logic f, input logic p);
        tick = t; flap = f; pipe_pass = p;
        @(posedge Clock);
        #1;
        tick = 1'b0; flap = 1'b0; pipe_pass = 1'b0;
    endtask

    // One tick followed by three quiet clocks.
    task automatic tick_period(output logic first_up, output logic first_down,
                               output int tot_up, output int tot_down, output int both);
        cyc(1'b1, 1'b0, 1'b0);
        first_up = move_up; first_down = move_down;
        tot_up = int'(move_up); tot_down = int'(move_down);
        both = int'(move_up & move_down);
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, 1'b0, 1'b0);
            tot_up += int'(move_up); tot_down += int'(move_down);
            both += int'(move_up & move_down);
        end
    endtask

    task automatic test_reset;
        RST = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        RST = 1'b1;
        n_checks++;
        if ({move_up, move_down, col_clear, playing, game_over, score} !== 13'h0) begin
            n_fail++;
            $display("FAIL reset_outputs: got up=%b dn=%b clr=%b play=%b over=%b score=%0d, want all 0",
                     move_up, move_down, col_clear, playing, game_over, score);
        end
    endtask

    task automatic test_flap_climb;
        logic fu, fd; int tu, td, bo;
        bird_pos = 16'h0100;
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (playing !== 1'b1) begin
            n_fail++; $display("FAIL start_play: playing=%b want 1", playing);
        end
        for (int k = 0; k < 2; k++) begin
            tick_period(fu, fd, tu, td, bo);
            n_checks++;
            if (fu !== 1'b1 || tu != 1 || td != 0 || bo != 0) begin
                n_fail++;
                $display("FAIL climb_tick%0d: first_up=%b ups=%0d downs=%0d both=%0d want 1/1/0/0",
                         k, fu, tu, td, bo);
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick_period(fu, fd, tu, td, bo);
            n_checks++;
            if (tu != 0 || td != ((k == 3) ? 1 : 0) || fd !== ((k == 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL fall_after_climb%0d: ups=%0d downs=%0d first_dn=%b", k, tu, td, fd);
            end
        end
    endtask

    task automatic test_gravity;
        logic fu, fd; int tu, td, bo;
        cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (score !== 8'd1) begin
            n_fail++; $display("FAIL score_inc: score=%0d want 1", score);
        end
        for (int k = 0; k < 4; k++) begin
            tick_period(fu, fd, tu, td, bo);
            n_checks++;
            if (tu != 0 || td != ((k == 3) ? 1 : 0) || fd !== ((k == 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL gravity%0d: ups=%0d downs=%0d first_dn=%b", k, tu, td, fd);
            end
        end
        // grav_cnt restarted: three more ticks must not fall
        for (int k = 0; k < 3; k++) begin
            tick_period(fu, fd, tu, td, bo);
            n_checks++;
            if (td != 0 || tu != 0) begin
                n_fail++; $display("FAIL grav_restart%0d: downs=%0d ups=%0d want 0", k, td, tu);
            end
        end
    endtask

    task automatic test_ground;
        bird_pos = 16'h0001;
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (move_down !== 1'b0 || game_over !== 1'b1 || playing !== 1'b0) begin
            n_fail++;
            $display("FAIL ground_death: dn=%b over=%b play=%b want 0/1/0", move_down, game_over, playing);
        end
        for (int k = 0; k < 3; k++) cyc(1'b1, 1'b0, 1'b1);
        n_checks++;
        if (score !== 8'd1 || move_up !== 1'b0 || move_down !== 1'b0) begin
            n_fail++; $display("FAIL dead_frozen: score=%0d want 1", score);
        end
    endtask

    task automatic test_pipe_hit;
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (col_clear !== 1'b1 || playing !== 1'b0 || game_over !== 1'b0 || score !== 8'd0) begin
            n_fail++;
            $display("FAIL exit_dead: clr=%b play=%b over=%b score=%0d want 1/0/0/0",
                     col_clear, playing, game_over, score);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (col_clear !== 1'b0 || playing !== 1'b0) begin
            n_fail++; $display("FAIL exit_no_play: clr=%b play=%b want 0/0", col_clear, playing);
        end
        bird_pos = 16'h0400;
        cyc(1'b0, 1'b1, 1'b0);
        pipe_mask = 16'h0C00;
        cyc(1'b1, 1'b0, 1'b0);
        n_checks++;
        if (game_over !== 1'b1 || move_up !== 1'b0) begin
            n_fail++; $display("FAIL pipe_death: over=%b up=%b want 1/0", game_over, move_up);
        end
        pipe_mask = 16'h0000;
        cyc(1'b0, 1'b1, 1'b0);
        n_checks++;
        if (col_clear !== 1'b1 || score !== 8'd0 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL pipe_clear: clr=%b score=%0d over=%b", col_clear, score, game_over);
        end
        cyc(1'b0, 1'b0, 1'b0);
        n_checks++;
        if (col_clear !== 1'b0 || playing !== 1'b0 || game_over !== 1'b0) begin
            n_fail++; $display("FAIL clear_one_cycle: clr=%b play=%b", col_clear, playing);
        end
    endtask

    task automatic test_ceiling;
        logic fu, fd; int tu, td, bo;
        bird_pos = 16'h8000;
        cyc(1'b0, 1'b1, 1'b0);
        tick_period(fu, fd, tu, td, bo);
        n_checks++;
        if (tu != 0 || td != 0 || game_over !== 1'b0 || playing !== 1'b1) begin
            n_fail++; $display("FAIL ceiling_clamp: ups=%0d downs=%0d over=%b", tu, td, game_over);
        end
        tu = 0; td = 0;
        for (int k = 0; k < 4; k++) begin
            int u, d;
            tick_period(fu, fd, u, d, bo);
            tu += u; td += d;
        end
        n_checks++;
        if (tu != 0 || td != 1) begin
            n_fail++; $display("FAIL ceiling_then_fall: ups=%0d downs=%0d want 0/1", tu, td);
        end
    endtask

    task automatic test_back_to_back;
        logic fu, fd; int tu, td, bo;
        bird_pos = 16'h0100;
        for (int k = 0; k < 255; k++) cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (score !== 8'd255) begin
            n_fail++; $display("FAIL score_255: score=%0d want 255", score);
        end
        for (int k = 0; k < 5; k++) cyc(1'b0, 1'b0, 1'b1);
        n_checks++;
        if (score !== 8'd255) begin
            n_fail++; $display("FAIL score_sat: score=%0d want 255", score);
        end
        cyc(1'b1, 1'b1, 1'b0);
        n_checks++;
        if (move_up !== 1'b0 || move_down !== 1'b0) begin
            n_fail++; $display("FAIL flap_tick_same: up=%b dn=%b want 0/0", move_up, move_down);
        end
        repeat (3) cyc(1'b0, 1'b0, 1'b0);
        tick_period(fu, fd, tu, td, bo);
        n_checks++;
        if (fu !== 1'b1 || tu != 1 || td != 0) begin
            n_fail++; $display("FAIL up_after_flap_tick: first_up=%b ups=%0d downs=%0d", fu, tu, td);
        end
    endtask

    initial begin
        test_reset();
        test_flap_climb();
        test_gravity();
        test_ground();
        test_pipe_hit();
        test_ceiling();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
